// File: rtl/ttt_move_controller.sv
// ttt_move_controller: tic-tac-toe turn controller owning the X/O boards.
// Decodes 1..9 move codes, rejects illegal moves and reports win/draw.
module position_decoder (
    input  logic       en,
    input  logic [3:0] pos,
    output logic [8:0] onehot
);
    always_comb onehot = (en && pos >= 4'd1 && pos <= 4'd9) ? 9'd1 << (pos - 4'd1) : 9'd0;
endmodule

module ttt_move_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic [8:0] x_board,
    output logic [8:0] o_board,
    output logic       turn,
    output logic       busy,
    output logic       illegal_move,
    output logic [1:0] winner,
    output logic       game_over
);
    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    logic [1:0] state_q, state_d, winner_q, winner_d;
    logic [8:0] x_q, x_d, o_q, o_d, dec;
    logic       turn_q, turn_d, busy_q, busy_d, illegal_q, illegal_d, over_q, over_d;
    logic       dec_en, legal;

    function automatic logic has_line(input logic [8:0] b);
        return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign dec_en = move_valid & (state_q == S_WAIT) & ~new_game;

    position_decoder u_dec (.en(dec_en), .pos(move_pos), .onehot(dec));

    // Out-of-range codes decode to zero, so a zero one-hot is itself illegal.
    assign legal = (|dec) & ~|(dec & (x_q | o_q));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        o_d       = o_q;
        turn_d    = turn_q;
        winner_d  = winner_q;
        over_d    = over_q;
        busy_d    = 1'b0;
        illegal_d = 1'b0;
        if (new_game) begin
            state_d  = S_WAIT;
            x_d      = '0;
            o_d      = '0;
            turn_d   = 1'b0;
            winner_d = 2'b00;
            over_d   = 1'b0;
        end else if (state_q == S_WAIT && move_valid) begin
            if (legal) begin
                x_d     = turn_q ? x_q : x_q | dec;
                o_d     = turn_q ? o_q | dec : o_q;
                state_d = S_CHECK;
                busy_d  = 1'b1;
            end else begin
                illegal_d = 1'b1;
            end
        end else if (state_q == S_CHECK) begin
            // Only the mover's board can have gained a line, so a 9th-move win beats a draw.
            if (has_line(turn_q ? o_q : x_q)) begin
                winner_d = turn_q ? 2'b10 : 2'b01;
                state_d  = S_OVER;
                over_d   = 1'b1;
            end else if (&(x_q | o_q)) begin
                winner_d = 2'b11;
                state_d  = S_OVER;
                over_d   = 1'b1;
            end else begin
                turn_d  = ~turn_q;
                state_d = S_WAIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_WAIT;
            x_q       <= '0;
            o_q       <= '0;
            turn_q    <= 1'b0;
            winner_q  <= 2'b00;
            over_q    <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            o_q       <= o_d;
            turn_q    <= turn_d;
            winner_q  <= winner_d;
            over_q    <= over_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
        end
    end

    assign x_board      = x_q;
    assign o_board      = o_q;
    assign turn         = turn_q;
    assign busy         = busy_q;
    assign illegal_move = illegal_q;
    assign winner       = winner_q;
    assign game_over    = over_q;
endmodule

// File: tb/tb_ttt_move_controller.sv
// tb_ttt_move_controller: directed plus random game play checked against a
// cell-array reference model of the tic-tac-toe rules.
module tb_ttt_move_controller;
    logic       clock = 1'b0;
    logic       reset, new_game, move_valid;
    logic [3:0] move_pos;
    logic [8:0] x_board, o_board;
    logic       turn, busy, illegal_move, game_over;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

    // Reference model: cell 0 empty, 1 X, 2 O; phase 0 waiting, 1 evaluating, 2 finished.
    int brd[9];
    int m_turn, m_phase, m_win, m_ill;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    ttt_move_controller dut (
        .clock(clock), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .x_board(x_board), .o_board(o_board), .turn(turn),
        .busy(busy), .illegal_move(illegal_move), .winner(winner), .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int board_of(input int p);
        int v = 0;
        for (int i = 0; i < 9; i++) if (brd[i] == p) v |= (1 << i);
        return v;
    endfunction

    function automatic bit line_for(input int p);
        for (int l = 0; l < 8; l++)
            if (brd[lines[l][0]] == p && brd[lines[l][1]] == p && brd[lines[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit board_full();
        for (int i = 0; i < 9; i++) if (brd[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) brd[i] = 0;
        m_turn = 0; m_phase = 0; m_win = 0;
    endtask

    task automatic model_edge(input bit mv, input int pos, input bit ng, input bit rs);
        m_ill = 0;
        if (rs || ng) model_clear();
        else if (m_phase == 1) begin
            if (line_for(m_turn + 1)) begin m_win = m_turn + 1; m_phase = 2; end
            else if (board_full()) begin m_win = 3; m_phase = 2; end
            else begin m_turn ^= 1; m_phase = 0; end
        end else if (m_phase == 0 && mv) begin
            if (pos >= 1 && pos <= 9 && brd[pos-1] == 0) begin brd[pos-1] = m_turn + 1; m_phase = 1; end
            else m_ill = 1;
        end
    endtask

    task automatic compare();
        chk("x_board", int'(x_board), board_of(1));
        chk("o_board", int'(o_board), board_of(2));
        chk("turn", int'(turn), m_turn);
        chk("busy", int'(busy), int'(m_phase == 1));
        chk("illegal_move", int'(illegal_move), m_ill);
        chk("winner", int'(winner), m_win);
        chk("game_over", int'(game_over), int'(m_phase == 2));
        chk("disjoint", int'(x_board & o_board), 0);
    endtask

    task automatic cycle(input bit mv, input int pos, input bit ng, input bit rs);
        move_valid = mv; move_pos = 4'(pos); new_game = ng; reset = rs;
        @(posedge clock);
        model_edge(mv, pos, ng, rs);
        #1;
        compare();
    endtask

    task automatic move(input int pos);
        cycle(1, pos, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        m_ill = 0;
        // Reset held two cycles
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("reset_x", int'(x_board), 0);
        chk("reset_winner", int'(winner), 0);
        // X row win
        move(5); move(1); move(4); move(9);
        cycle(1, 6, 0, 0);
        chk("row_x_board", int'(x_board), 'h038);
        chk("row_o_board", int'(o_board), 'h101);
        cycle(0, 0, 0, 0);
        chk("row_winner", int'(winner), 1);
        chk("row_over", int'(game_over), 1);
        cycle(1, 2, 0, 0);
        chk("row_ignore_o", int'(o_board), 'h101);
        // Illegal requests
        cycle(0, 0, 1, 0);
        move(5);
        cycle(1, 5, 0, 0);
        chk("ill_pulse", int'(illegal_move), 1);
        chk("ill_o_board", int'(o_board), 0);
        chk("ill_turn", int'(turn), 1);
        cycle(1, 0, 0, 0);
        cycle(1, 12, 0, 0);
        chk("ill_back_to_back", int'(illegal_move), 1);
        cycle(0, 0, 0, 0);
        chk("ill_drop", int'(illegal_move), 0);
        // Draw
        cycle(0, 0, 1, 0);
        foreach (lines[i]) ;
        move(1); move(2); move(3); move(5); move(4); move(6); move(8); move(7); move(9);
        chk("draw_winner", int'(winner), 3);
        chk("draw_x", int'(x_board), 'h18D);
        chk("draw_o", int'(o_board), 'h072);
        // Busy drop: held request accepted once
        cycle(0, 0, 1, 0);
        cycle(1, 3, 0, 0);
        cycle(1, 3, 0, 0);
        chk("busy_no_ill", int'(illegal_move), 0);
        cycle(0, 0, 0, 0);
        chk("busy_o", int'(o_board), 0);
        // Restart with simultaneous move, then reset during evaluation
        move(1);
        cycle(1, 5, 1, 0);
        chk("restart_x", int'(x_board), 0);
        chk("restart_turn", int'(turn), 0);
        move(1); move(2);
        cycle(1, 5, 0, 0);
        cycle(0, 0, 0, 1);
        chk("rst_check_turn", int'(turn), 0);
        chk("rst_check_winner", int'(winner), 0);
        // Random play
        for (int n = 0; n < 2000; n++) begin
            automatic int r = $urandom_range(0, 99);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15), r < 2, r == 2);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ttt_move_controller.md
# ttt_move_controller

Sequential turn controller for the two-player tic-tac-toe datapath. Accepts move requests on a 1..9 position code, one-hot decodes them through `position_decoder` (enable tied to move acceptance) and rejects illegal moves. It owns the X and O board registers, alternates turns, and detects win/draw after every accepted move. It sits between the input/debounce logic and the display/win-indicator logic.

## Interface
- No parameters. Board is fixed at 3x3, with position codes 1..9 mapped to bits 0..8.
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- new_game  input  1  synchronous restart; same effect as reset
- move_valid  input  1  one-cycle move request strobe
- move_pos  input  4  requested position; legal values 1..9
- x_board  output  9  one-hot-per-cell X occupancy
- o_board  output  9  one-hot-per-cell O occupancy
- turn  output  1  0 = X to move, 1 = O to move
- busy  output  1  high while in CHECK; requests ignored
- illegal_move  output  1  one-cycle pulse on rejected request
- winner  output  2  00 none, 01 X, 10 O, 11 draw
- game_over  output  1  high in state OVER

## Operation
- States:
  - WAIT: ready for a move; turn selects the player.
  - CHECK: evaluating the board.
  - OVER: game finished.
- Reset or new_game, registered on the next edge:
  - x_board = o_board = 0
  - turn = 0
  - winner = 00
  - game_over = 0
  - busy = 0
  - illegal_move = 0
  - state = WAIT
- new_game has priority over any simultaneous move_valid.
- WAIT, move_valid = 1:
  - Legal: move_pos in 1..9 and the decoded cell is clear in (x_board | o_board).
  - Legal move: OR the decoded one-hot into the board selected by turn, then go to CHECK.
  - Illegal move: pulse illegal_move for one cycle. Boards, turn and state are unchanged, and the same player moves again.
  - move_pos = 0 or 10..15 is illegal, because the decoder outputs zero for those codes.
- CHECK:
  - Test the 8 lines (rows {0,1,2},{3,4,5},{6,7,8}; columns {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}) against the board of the player who just moved only.
  - Line complete: winner = 01 (X) or 10 (O), go to OVER.
  - Else, if all 9 cells are occupied: winner = 11, go to OVER.
  - Else: toggle turn, go to WAIT.
  - A win on the 9th move reports a win, not a draw.
- move_valid in CHECK or OVER: ignored. No illegal pulse and no state change.
- OVER:
  - Holds boards and winner until reset or new_game.
  - turn is not toggled after the final move.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Legal request sampled at edge T:
  - Board bit visible and busy = 1 after T.
  - At edge T+1: winner/game_over, or the turn toggle, visible; busy = 0.
  - The next request is accepted at edge T+2 at the earliest.
- Illegal request at edge T: illegal_move = 1 for exactly the cycle after T. A back-to-back illegal request keeps it high one more cycle.
- Reset asserted in CHECK: the reset values win. No winner update and no turn toggle occur.
- x_board & o_board is always 0, and the popcount difference (X minus O) is always 0 or 1.

## Test plan
- **Reset:** assert reset 2 cycles -> x_board = o_board = 0, turn = 0, winner = 00, busy = 0, game_over = 0.
- **X row win:** X5, O1, X4, O9, X6 (two idle cycles between moves).
  - After X6, x_board = 0x038 and o_board = 0x101.
  - winner = 01 and game_over = 1 two edges after the final strobe.
  - A further move_valid has no effect.
- **Illegal:**
  - X5, then O with pos 5 -> illegal_move pulses 1 cycle, o_board = 0, turn stays 1.
  - O with pos 0, then O with pos 12 -> two pulses, no board change.
- **Draw:** X1, O2, X3, O5, X4, O6, X8, O7, X9 -> winner = 11, x_board = 0x18D, o_board = 0x072.
- **Busy drop:** move_valid with pos 3 held high for 2 cycles -> only the first is accepted, no illegal pulse, o_board unchanged.
- **Restart:** new_game together with move_valid mid-game -> boards cleared, turn = 0, move discarded; reset asserted in CHECK -> turn = 0, winner = 00.
